// File: rtl/gpr_scoreboard_if.sv
// Register-file scoreboard bus: write port, two read ports and the reservation port.
interface gpr_scoreboard_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
);
    logic             reg_write;
    logic [AW-1:0]    sel_d;
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    sel_a;
    logic [AW-1:0]    sel_b;
    logic [WIDTH-1:0] bus_a;
    logic [WIDTH-1:0] bus_b;
    logic             rdy_a;
    logic             rdy_b;
    logic             rsv;
    logic [AW-1:0]    sel_r;
    logic             rsv_ok;
    logic [AW:0]      busy_cnt;

    modport master (
        output reg_write, sel_d, data_in, sel_a, sel_b, rsv, sel_r,
        input  bus_a, bus_b, rdy_a, rdy_b, rsv_ok, busy_cnt
    );

    modport slave (
        input  reg_write, sel_d, data_in, sel_a, sel_b, rsv, sel_r,
        output bus_a, bus_b, rdy_a, rdy_b, rsv_ok, busy_cnt
    );
endinterface

// File: rtl/gpr_scoreboard.sv
// General-purpose register file with per-register busy bits for in-order issue
// scoreboarding: combinational reads with optional write bypass, reservations, busy count.
module gpr_scoreboard #(
    parameter int WIDTH   = 8,
    parameter int AW      = 3,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input logic            clk,
    input logic            reset,
    gpr_scoreboard_if.slave sb
);
    localparam int unsigned DEPTH = 1 << AW;

    logic             wr_i;
    logic [AW-1:0]    sel_d_i;
    logic [WIDTH-1:0] data_i;
    logic             rsv_i;
    logic [AW-1:0]    sel_r_i;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;

    logic wr_en, rsv_ok_raw, set_en, clr_en, inc, dec;
    logic [WIDTH:0] port_a, port_b;

    assign wr_i    = sb.reg_write;
    assign sel_d_i = sb.sel_d;
    assign data_i  = sb.data_in;
    assign rsv_i   = sb.rsv;
    assign sel_r_i = sb.sel_r;

    function automatic logic [WIDTH:0] read_port(input logic [AW-1:0] sel);
        if (!reset)
            return {1'b1, {WIDTH{1'b0}}};
        if (ZERO_R0 != 0 && sel == '0)
            return {1'b1, {WIDTH{1'b0}}};
        if (BYPASS != 0 && wr_i && sel_d_i == sel)
            return {1'b1, data_i};
        return {!busy_q[sel], regs_q[sel]};
    endfunction

    always_comb begin
        port_a = read_port(sb.sel_a);
        port_b = read_port(sb.sel_b);
    end

    assign sb.bus_a    = port_a[WIDTH-1:0];
    assign sb.rdy_a    = port_a[WIDTH];
    assign sb.bus_b    = port_b[WIDTH-1:0];
    assign sb.rdy_b    = port_b[WIDTH];
    assign sb.rsv_ok   = !reset || rsv_ok_raw;
    assign sb.busy_cnt = cnt_q;

    // Write-clear is applied before reservation-set so a same-register pair ends busy;
    // the count moves only where a busy bit actually changes.
    always_comb begin
        wr_en      = wr_i && !(ZERO_R0 != 0 && sel_d_i == '0);
        rsv_ok_raw = !busy_q[sel_r_i] || (wr_i && sel_d_i == sel_r_i);
        set_en     = rsv_i && rsv_ok_raw && !(ZERO_R0 != 0 && sel_r_i == '0);
        clr_en     = wr_en && busy_q[sel_d_i];
        inc        = set_en && !busy_q[sel_r_i];
        dec        = clr_en && !(set_en && sel_r_i == sel_d_i);

        busy_d = busy_q;
        if (clr_en)
            busy_d[sel_d_i] = 1'b0;
        if (set_en)
            busy_d[sel_r_i] = 1'b1;

        cnt_d = cnt_q;
        if (inc && !dec)
            cnt_d = cnt_q + 1'b1;
        else if (dec && !inc)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en)
                regs_q[sel_d_i] <= data_i;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: doc/gpr_scoreboard.md
GPR_SCOREBOARD -- requirements
Module: gpr_scoreboard

Interface
REQ-001 Parameter WIDTH, default 8: data width of each register.
REQ-002 Parameter AW, default 3: address width; DEPTH = 2**AW registers.
REQ-003 Parameter ZERO_R0, default 0: when 1, r0 is hardwired zero.
REQ-004 Parameter BYPASS, default 1: when 1, same-cycle write data is forwarded to read ports.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 reg_write  input  1  write strobe for sel_d/data_in.
REQ-008 sel_d  input  AW  write (writeback) address.
REQ-009 data_in  input  WIDTH  write data.
REQ-010 sel_a, sel_b  input  AW each  read addresses.
REQ-011 bus_a, bus_b  output  WIDTH each  read data.
REQ-012 rdy_a, rdy_b  output  1 each  addressed register not pending (after bypass).
REQ-013 rsv  input  1  reserve request: mark sel_r pending.
REQ-014 sel_r  input  AW  reserve address.
REQ-015 rsv_ok  output  1  combinational: reservation of sel_r is acceptable this cycle.
REQ-016 busy_cnt  output  AW+1  number of pending registers.

Function
REQ-017 Storage: DEPTH x WIDTH registers plus one busy bit per register.
REQ-018 Read is combinational: bus_a = r[sel_a], bus_b = r[sel_b], unless REQ-019 or REQ-020 applies.
REQ-019 BYPASS=1 and reg_write and sel_d==sel_a: bus_a = data_in and rdy_a = 1 (same for port b); BYPASS=0: the old value is read and the write is visible in the next cycle.
REQ-020 ZERO_R0=1: writes to r0 are discarded; reads of r0 return 0 with rdy = 1; r0 is never busy; reserving r0 is accepted and has no effect.
REQ-021 rdy_x = !busy[sel_x] absent bypass.
REQ-022 Write: on clk rise with reg_write, r[sel_d] <= data_in and busy[sel_d] <= 0; a write to a non-busy register is legal.
REQ-023 rsv_ok = !busy[sel_r] OR (reg_write AND sel_d==sel_r).
REQ-024 Reservation accepted iff rsv AND rsv_ok; then busy[sel_r] <= 1. A rejected reservation leaves all state unchanged.
REQ-025 Simultaneous write and accepted reservation to the same register: data is written and busy ends at 1 (the reservation wins).
REQ-026 busy_cnt tracks the population of busy bits every cycle: +1 for an accepted reservation of a non-busy register, -1 for a write clearing a busy register, net 0 when both occur or for the same-register case in REQ-025.
REQ-027 busy_cnt never exceeds DEPTH (DEPTH-1 when ZERO_R0=1) and never wraps below 0.

Reset
REQ-028 reset low asynchronously clears all registers, all busy bits and busy_cnt to 0; rdy_a = rdy_b = 1, bus_a = bus_b = 0, and rsv_ok = 1 while reset is asserted.
REQ-029 reset asserted mid-operation discards pending reservations; reg_write and rsv are ignored until the first clk rise after reset deasserts.

Verification
REQ-030 Reset, then write r3=0xA5; read sel_a=3 next cycle -> bus_a=0xA5, rdy_a=1, busy_cnt=0.
REQ-031 Reserve r5 -> rdy_b=0 for sel_b=5, busy_cnt=1; reserve r5 again -> rsv_ok=0, busy_cnt stays 1; write r5=0x3C -> same cycle bus_b=0x3C, rdy_b=1 (BYPASS=1); next cycle busy_cnt=0.
REQ-032 Same cycle write r2=0x11 and reserve r2 -> rsv_ok=1; afterwards r2=0x11, busy[2]=1, busy_cnt=1.
REQ-033 ZERO_R0=1: write r0=0xFF, reserve r0 -> bus_a(sel_a=0)=0, rdy_a=1, busy_cnt=0.
REQ-034 Reserve all 8 registers -> busy_cnt=8; assert reset mid-cycle -> busy_cnt=0 and bus_a=0 immediately, without a clock edge.
REQ-035 WIDTH=16, AW=4: write r15=0xBEEF, reserve r15 -> bus_a=0xBEEF, rdy_a=0, busy_cnt=1.
